// File: rtl/remap_pipe_if.sv
// Operand/result stream bundle for remap_pipe: operand valid/ready in, {k, m2} result valid/ready out.
interface remap_pipe_if #(
   parameter int NUM_W = 32
);
   logic [NUM_W-1:0] num;
   logic             num_vld;
   logic             num_rdy;
   logic [NUM_W-1:0] rslt;
   logic             zero;
   logic             rslt_vld;
   logic             rslt_rdy;

   modport slave (
      input  num, num_vld, rslt_rdy,
      output num_rdy, rslt, zero, rslt_vld
   );

   modport master (
      output num, num_vld, rslt_rdy,
      input  num_rdy, rslt, zero, rslt_vld
   );
endinterface

// File: rtl/remap_pipe.sv
// Three-stage leading-one/normalise + log2 curve-correction remap with valid/ready on both sides.
// Define REMAP_CORR_EN to build the correction multiplier; otherwise m2 = m1 (plain Mitchell).
module remap_pipe #(
   parameter int NUM_W = 32
) (
   input logic        clk,
   input logic        rst_n,
   remap_pipe_if.slave bus
);
   localparam int K_W = $clog2(NUM_W);
   localparam int M_W = NUM_W - K_W;
   localparam logic [K_W-1:0] K_TOP = K_W'(NUM_W - 1);

   logic             rdy_en;
   logic             s1_vld, s2_vld, s3_vld;
   logic             s1_load, s2_load, s3_load, accept;
   logic [K_W-1:0]   lod_k, s1_k, s2_k;
   logic [M_W-1:0]   lod_m1, s1_m1, s2_m1, m2;
   logic             s1_zero, s2_zero, s3_zero;
   logic [NUM_W-1:0] norm, s3_rslt;

   // Bubble-collapsing load chain driven back from the output register.
   assign s3_load     = ~s3_vld | bus.rslt_rdy;
   assign s2_load     = ~s2_vld | s3_load;
   assign s1_load     = ~s1_vld | s2_load;
   assign bus.num_rdy = rdy_en & s1_load;
   assign accept      = bus.num_vld & bus.num_rdy;

   // m1 is the NUM_W-1 bits below the leading one, top M_W of them kept.
   always_comb begin
      lod_k = '0;
      for (int i = 0; i < NUM_W; i++) begin
         if (bus.num[i]) lod_k = K_W'(i);
      end
      norm   = bus.num << (K_TOP - lod_k);
      lod_m1 = M_W'(norm >> (K_W - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en  <= 1'b0;
         s1_vld  <= 1'b0;
         s1_k    <= '0;
         s1_m1   <= '0;
         s1_zero <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (s1_load) begin
            s1_vld <= accept;
            if (accept) begin
               s1_k    <= lod_k;
               s1_m1   <= lod_m1;
               s1_zero <= (bus.num == '0);
            end
         end
      end
   end

`ifdef REMAP_CORR_EN
   localparam logic [M_W-1:0] M_MAX = '1;
   logic [2*M_W-1:0] prod_next, s2_prod;

   always_comb begin
      prod_next = (2*M_W)'(s1_m1) * (2*M_W)'(M_MAX - s1_m1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_prod <= '0;
      end else if (s2_load && s1_vld) begin
         s2_prod <= prod_next;
      end
   end

   // m1*(1-m1)/4 in fixed point; the sum stays below 2^M_W so no saturation.
   assign m2 = s2_m1 + M_W'(s2_prod >> (M_W + 2));
`else
   assign m2 = s2_m1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld  <= 1'b0;
         s2_k    <= '0;
         s2_m1   <= '0;
         s2_zero <= 1'b0;
      end else if (s2_load) begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_k    <= s1_k;
            s2_m1   <= s1_m1;
            s2_zero <= s1_zero;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_vld  <= 1'b0;
         s3_rslt <= '0;
         s3_zero <= 1'b0;
      end else if (s3_load) begin
         s3_vld <= s2_vld;
         if (s2_vld) begin
            s3_rslt <= s2_zero ? '0 : {s2_k, m2};
            s3_zero <= s2_zero;
         end
      end
   end

   assign bus.rslt     = s3_rslt;
   assign bus.zero     = s3_zero;
   assign bus.rslt_vld = s3_vld;
endmodule

// File: tb/tb_remap_pipe.sv
// Scoreboard bench for remap_pipe: directed spec vectors plus random valid/ready traffic vs. an arithmetic model.
module tb_remap_pipe;
   typedef struct packed {
      logic [31:0] rslt;
      logic        zero;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   remap_pipe_if #(.NUM_W(32)) bus ();
   remap_pipe #(.NUM_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // Reference: k = floor(log2 n), m1 = fraction below the leading one scaled to 27 bits.
   function automatic exp_t model(input logic [31:0] n);
      exp_t e;
      int k;
      longint unsigned frac, m1, corr;
      e.zero = (n == 0);
      e.rslt = 32'd0;
      if (n == 0) return e;
      k    = $clog2({1'b0, n} + 33'd1) - 1;
      frac = longint'(n) - (64'd1 << k);
      m1   = (frac << 27) >> k;
`ifdef REMAP_CORR_EN
      corr = (m1 * ((64'd1 << 27) - 1 - m1)) >> 29;
`else
      corr = 0;
`endif
      e.rslt = 32'((longint'(k) << 27) + m1 + corr);
      return e;
   endfunction

   function automatic logic [31:0] gen_num();
      case ($urandom % 5)
         0:       return 32'd0;
         1:       return 32'd1 << ($urandom % 32);
         2:       return $urandom >> ($urandom % 32);
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=0x%08h want=0x%08h", name, got, want);
      end
   endtask

   // Caller sits at a falling edge; returns at the falling edge after the accept.
   task automatic push_op(input logic [31:0] n, input exp_t e);
      int t = 0;
      bus.num     = n;
      bus.num_vld = 1'b1;
      #1;
      while (!bus.num_rdy && t < 20) begin
         @(negedge clk); #1;
         t++;
      end
      chk("accept", 32'(bus.num_rdy), 32'd1);
      if (bus.num_rdy) sb.push_back(e);
      @(negedge clk);
      bus.num_vld = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      bus.rslt_rdy = 1'b1;
      while (sb.size() > 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: pops on every output transfer, and checks stability while stalled.
   initial begin : monitor
      logic        hold_v = 1'b0;
      logic [31:0] hold_r = '0;
      logic        hold_z = 1'b0;
      exp_t        e;
      forever begin
         @(negedge clk); #2;
         if (!rst_n) begin
            hold_v = 1'b0;
            continue;
         end
         if (hold_v) begin
            total++;
            if (!bus.rslt_vld || bus.rslt !== hold_r || bus.zero !== hold_z) begin
               bad++;
               $display("FAIL stall_stable got vld=%0b rslt=0x%08h zero=%0b want vld=1 rslt=0x%08h zero=%0b",
                        bus.rslt_vld, bus.rslt, bus.zero, hold_r, hold_z);
            end
         end
         if (bus.rslt_vld && bus.rslt_rdy) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_result got rslt=0x%08h zero=%0b want none", bus.rslt, bus.zero);
            end else begin
               e = sb.pop_front();
               if (bus.rslt !== e.rslt || bus.zero !== e.zero) begin
                  bad++;
                  $display("FAIL result got rslt=0x%08h zero=%0b want rslt=0x%08h zero=%0b",
                           bus.rslt, bus.zero, e.rslt, e.zero);
               end
            end
            hold_v = 1'b0;
         end else begin
            hold_v = bus.rslt_vld;
            hold_r = bus.rslt;
            hold_z = bus.zero;
         end
      end
   end

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      int lat, run, n_acc, stale, sent, cyc;
      logic [31:0] v;
      logic acc;
      exp_t e;

      rst_n        = 1'b0;
      bus.num      = '0;
      bus.num_vld  = 1'b0;
      bus.rslt_rdy = 1'b0;
      #1;
      chk("rst_vld", 32'(bus.rslt_vld), 32'd0);
      chk("rst_rslt", bus.rslt, 32'd0);
      chk("rst_zero", 32'(bus.zero), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("rdy_after_rst", 32'(bus.num_rdy), 32'd1);
      @(negedge clk);

      // num=3 with latency measurement
      bus.rslt_rdy = 1'b1;
`ifdef REMAP_CORR_EN
      push_op(32'd3, '{rslt: 32'h0C7F_FFFF, zero: 1'b0});
`else
      push_op(32'd3, '{rslt: 32'h0C00_0000, zero: 1'b0});
`endif
      lat = 1;
      #1;
      while (!bus.rslt_vld && lat < 10) begin
         @(negedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'd3);
      wait_drain();

      // Boundary operands
      push_op(32'h8000_0000, '{rslt: 32'hF800_0000, zero: 1'b0});
      push_op(32'd1,         '{rslt: 32'h0,         zero: 1'b0});
      push_op(32'd0,         '{rslt: 32'h0,         zero: 1'b1});
      wait_drain();

      // Back-to-back stream: four consecutive output cycles
      fork
         begin
            push_op(32'h10, '{rslt: 32'h2000_0000, zero: 1'b0});
            push_op(32'h20, '{rslt: 32'h2800_0000, zero: 1'b0});
            push_op(32'h40, '{rslt: 32'h3000_0000, zero: 1'b0});
            push_op(32'h80, '{rslt: 32'h3800_0000, zero: 1'b0});
         end
         begin
            int t = 0;
            run = 0;
            #1;
            while (!bus.rslt_vld && t < 20) begin
               @(negedge clk); #1;
               t++;
            end
            while (bus.rslt_vld && run < 10) begin
               run++;
               @(negedge clk); #1;
            end
         end
      join
      chk("stream_run", 32'(run), 32'd4);
      wait_drain();

      // Backpressure: three held, input ready drops
      bus.rslt_rdy = 1'b0;
      bus.num_vld  = 1'b1;
      n_acc = 0;
      v = 32'h100;
      for (int c = 0; c < 8; c++) begin
         bus.num = v;
         #1;
         if (bus.num_rdy) begin
            sb.push_back(model(v));
            n_acc++;
            v = v * 3 + 1;
         end
         @(negedge clk);
      end
      bus.num_vld = 1'b0;
      chk("bp_accepted", 32'(n_acc), 32'd3);
      #1;
      chk("bp_rdy_low", 32'(bus.num_rdy), 32'd0);
      chk("bp_vld_high", 32'(bus.rslt_vld), 32'd1);
      @(negedge clk);
      wait_drain();

      // Reset with operands in flight
      bus.rslt_rdy = 1'b0;
      push_op(32'h1234, model(32'h1234));
      push_op(32'h5678, model(32'h5678));
      @(negedge clk); @(negedge clk); #1;
      chk("pre_rst_vld", 32'(bus.rslt_vld), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("mid_rst_vld", 32'(bus.rslt_vld), 32'd0);
      chk("mid_rst_rslt", bus.rslt, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.rslt_rdy = 1'b1;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk); #1;
         if (bus.rslt_vld) stale++;
      end
      chk("no_stale", 32'(stale), 32'd0);

      // Random traffic vs. model
      @(negedge clk);
      sent = 0;
      cyc  = 0;
      acc  = 1'b0;
      while (sent < 10000 && cyc < 60000) begin
         if (acc) bus.num_vld = 1'b0;
         bus.rslt_rdy = ($urandom % 4) != 0;
         if (!bus.num_vld && ($urandom % 4) != 0) begin
            bus.num     = gen_num();
            bus.num_vld = 1'b1;
         end
         #1;
         acc = bus.num_vld && bus.num_rdy;
         if (acc) begin
            e = model(bus.num);
            sb.push_back(e);
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      bus.num_vld = 1'b0;
      chk("random_sent", 32'(sent), 32'd10000);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
